sdram_phase_scan: RTL and testbench

Automatic SDRAM clock-phase calibrator. It sits between the memory tester's pass/fail counters and the dynamic-phase inputs of the SDRAM PLL, replacing manual button stepping. It sweeps the chip-clock phase through one full rotation and scores each step as good or bad. It then moves the phase to the centre of the longest circular run of good steps and reports the result for display.

---
 rtl/sdram_phase_scan_pkg.sv | 29 ++
 rtl/sdram_phase_window.sv | 107 ++++++++++
 rtl/sdram_phase_scan.sv | 246 ++++++++++++++++++++++++
 tb/tb_sdram_phase_scan.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_phase_scan_pkg.sv
// Shared types and helpers for the SDRAM clock-phase calibrator.
package sdram_phase_scan_pkg;

  // Calibrator sequencer states.
  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_SNAP,
    S_MEASURE,
    S_STEP_HI,
    S_STEP_LO,
    S_ANALYZE,
    S_MOVE_HI,
    S_MOVE_LO,
    S_DONE
  } state_e;

  // Default number of phase steps per full PLL rotation.
  localparam int unsigned DEF_STEPS = 16;

  // Width of a step index, log2(steps); never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  // Step-index width for the default rotation.
  localparam int unsigned DEF_STEP_W = step_w(DEF_STEPS);

endpackage

// File: rtl/sdram_phase_window.sv
// Serial circular longest-run finder over the good-step map.
// A start pulse begins a 2*STEPS-cycle scan; done_o marks the last scan
// cycle, on which best_o/win_len_o/fail_o carry the final result.
module sdram_phase_window
  import sdram_phase_scan_pkg::*;
#(
  parameter  int unsigned STEPS = DEF_STEPS,
  localparam int unsigned W     = step_w(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [STEPS-1:0] good_map_i,
  output logic             done_o,
  output logic             fail_o,
  output logic [W-1:0]     best_o,
  output logic [W:0]       win_len_o
);

  // Two passes over the map so that a run crossing index 0 is seen whole.
  localparam logic [W:0] K_LAST   = (W+1)'(2 * STEPS - 1);
  localparam logic [W:0] LEN_FULL = (W+1)'(STEPS);

  logic         active_q, active_d;
  logic [W:0]   k_q, k_d;
  logic [W-1:0] run_start_q, run_start_d;
  logic [W:0]   run_len_q, run_len_d;
  logic [W-1:0] top_start_q, top_start_d;
  logic [W:0]   top_len_q, top_len_d;
  logic [W-1:0] idx;
  logic         last;

  // Scan step: extend or break the current run, keep the strictly longest.
  // Strict '>' keeps the first run found at a given length, which is the
  // one with the lowest start index.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    active_d    = active_q;
    k_d         = k_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    top_start_d = top_start_q;
    top_len_d   = top_len_q;
    idx         = k_q[W-1:0];
    last        = active_q && (k_q == K_LAST);

    if (start_i) begin
      active_d    = 1'b1;
      k_d         = '0;
      run_start_d = '0;
      run_len_d   = '0;
      top_start_d = '0;
      top_len_d   = '0;
    end else if (active_q) begin
      k_d = k_q + (W+1)'(1);
      if (last) begin
        active_d = 1'b0;
      end
      if (good_map_i[idx]) begin
        if (run_len_q == '0) begin
          run_start_d = idx;
        end
        // An all-good map would otherwise count past one full rotation.
        if (run_len_q != LEN_FULL) begin
          run_len_d = run_len_q + (W+1)'(1);
        end
      end else begin
        run_len_d = '0;
      end
      if (run_len_d > top_len_q) begin
        top_len_d   = run_len_d;
        top_start_d = run_start_d;
      end
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      active_q    <= 1'b0;
      k_q         <= '0;
      run_start_q <= '0;
      run_len_q   <= '0;
      top_start_q <= '0;
      top_len_q   <= '0;
    end else begin
      active_q    <= active_d;
      k_q         <= k_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      top_start_q <= top_start_d;
      top_len_q   <= top_len_d;
    end
  end

  // Results include the final scan cycle, so they are ready with done_o.
  // A full-rotation window has no meaningful centre and maps to step 0.
  assign done_o    = last;
  assign fail_o    = (top_len_d == '0);
  assign win_len_o = top_len_d;
  assign best_o    = (fail_o || (top_len_d == LEN_FULL)) ? '0
                   : top_start_d + top_len_d[W:1];

endmodule

// File: rtl/sdram_phase_scan.sv
// Automatic SDRAM clock-phase calibrator: sweeps the PLL phase one full
// rotation, scores each step from the tester counters, then moves the phase
// to the centre of the longest circular run of good steps.
module sdram_phase_scan
  import sdram_phase_scan_pkg::*;
#(
  parameter  int unsigned STEPS    = DEF_STEPS,
  parameter  int unsigned SETTLE   = 1024,
  parameter  int unsigned PASS_MIN = 2,
  parameter  int unsigned TIMEOUT  = 1 << 24,
  parameter  int unsigned PULSE    = 4,
  localparam int unsigned W        = step_w(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      passcount,
  input  logic [31:0]      failcount,
  output logic             phasedir,
  output logic             phasestep,
  output logic             phaseloadreg,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [STEPS-1:0] good_map,
  output logic [W-1:0]     best,
  output logic [W:0]       win_len,
  output logic [W-1:0]     phase
);

  localparam logic [31:0]  SETTLE_LAST  = 32'(SETTLE - 1);
  localparam logic [31:0]  TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0]  PULSE_LAST   = 32'(PULSE - 1);
  localparam logic [31:0]  PASS_THRESH  = 32'(PASS_MIN);
  localparam logic [W-1:0] I_LAST       = W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      p0_q, p0_d;
  logic [31:0]      f0_q, f0_d;
  logic [W-1:0]     i_q, i_d;
  logic [W-1:0]     i_inc;
  logic [W-1:0]     phase_q, phase_d;
  logic [STEPS-1:0] map_q, map_d;
  logic [W-1:0]     best_q, best_d;
  logic [W:0]       win_len_q, win_len_d;
  logic             fail_q, fail_d;
  logic             step_q, step_d;
  logic [31:0]      pass_delta;
  logic             cnt_pulse_end;

  logic             win_start;
  logic             win_done;
  logic             win_fail;
  logic [W-1:0]     win_best;
  logic [W:0]       win_len_w;

  sdram_phase_window #(
    .STEPS (STEPS)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .start_i    (win_start),
    .good_map_i (map_q),
    .done_o     (win_done),
    .fail_o     (win_fail),
    .best_o     (win_best),
    .win_len_o  (win_len_w)
  );

  // Counter advance is modular, so a passcount wrap between the snapshot
  // and the measurement still yields the true delta.
  assign pass_delta    = passcount - p0_q;
  assign cnt_pulse_end = (cnt_q == PULSE_LAST);
  assign i_inc         = i_q + W'(1);

  // Sequencer next-state logic: sweep, score, analyse, move.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p0_d      = p0_q;
    f0_d      = f0_q;
    i_d       = i_q;
    phase_d   = phase_q;
    map_d     = map_q;
    best_d    = best_q;
    win_len_d = win_len_q;
    fail_d    = fail_q;
    win_start = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SETTLE;
          cnt_d     = '0;
          i_d       = '0;
          map_d     = '0;
          best_d    = '0;
          win_len_d = '0;
          fail_d    = 1'b0;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SNAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_SNAP: begin
        p0_d    = passcount;
        f0_d    = failcount;
        cnt_d   = '0;
        state_d = S_MEASURE;
      end

      // A fail change wins over a simultaneous pass threshold.
      S_MEASURE: begin
        if (failcount != f0_q) begin
          map_d[i_q] = 1'b0;
          state_d    = S_STEP_HI;
          cnt_d      = '0;
        end else if (pass_delta >= PASS_THRESH) begin
          map_d[i_q] = 1'b1;
          state_d    = S_STEP_HI;
          cnt_d      = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          map_d[i_q] = 1'b0;
          state_d    = S_STEP_HI;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_STEP_HI: begin
        if (cnt_pulse_end) begin
          state_d = S_STEP_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // After STEPS pulses the PLL is back where the sweep began.
      S_STEP_LO: begin
        if (cnt_pulse_end) begin
          cnt_d   = '0;
          phase_d = phase_q + W'(1);
          i_d     = i_inc;
          if (i_q == I_LAST) begin
            state_d   = S_ANALYZE;
            win_start = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_ANALYZE: begin
        if (win_done) begin
          best_d    = win_best;
          win_len_d = win_len_w;
          fail_d    = win_fail;
          cnt_d     = '0;
          i_d       = '0;
          state_d   = (win_best == '0) ? S_DONE : S_MOVE_HI;
        end
      end

      S_MOVE_HI: begin
        if (cnt_pulse_end) begin
          state_d = S_MOVE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // i counts move pulses issued so far.
      S_MOVE_LO: begin
        if (cnt_pulse_end) begin
          cnt_d   = '0;
          phase_d = phase_q + W'(1);
          i_d     = i_inc;
          state_d = (i_inc == best_q) ? S_DONE : S_MOVE_HI;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // phasestep is registered from the next state, so it is high exactly
    // during the HI states with no combinational path from the inputs.
    step_d = (state_d == S_STEP_HI) || (state_d == S_MOVE_HI);
  end

  // Sequencer state and output registers; reset aborts any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p0_q      <= '0;
      f0_q      <= '0;
      i_q       <= '0;
      phase_q   <= '0;
      map_q     <= '0;
      best_q    <= '0;
      win_len_q <= '0;
      fail_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p0_q      <= p0_d;
      f0_q      <= f0_d;
      i_q       <= i_d;
      phase_q   <= phase_d;
      map_q     <= map_d;
      best_q    <= best_d;
      win_len_q <= win_len_d;
      fail_q    <= fail_d;
      step_q    <= step_d;
    end
  end

  // Forward stepping only; the PLL counter select is never reloaded.
  assign phasedir     = 1'b0;
  assign phaseloadreg = 1'b0;
  assign phasestep    = step_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign fail         = fail_q;
  assign good_map     = map_q;
  assign best         = best_q;
  assign win_len      = win_len_q;
  assign phase        = phase_q;

endmodule

// File: tb/tb_sdram_phase_scan.sv
// Self-checking bench for sdram_phase_scan with a behavioural tester/PLL
// model and a scoreboard of expected calibration results.
module tb_sdram_phase_scan;

  localparam int unsigned STEPS    = 16;
  localparam int unsigned SETTLE   = 8;
  localparam int unsigned PASS_MIN = 2;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned PULSE    = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] passcount;
  logic [31:0] failcount;
  logic        phasedir, phasestep, phaseloadreg;
  logic        busy, done, fail;
  logic [15:0] good_map;
  logic [3:0]  best;
  logic [4:0]  win_len;
  logic [3:0]  phase;

  always #5 clk = ~clk;

  sdram_phase_scan #(
    .STEPS    (STEPS),
    .SETTLE   (SETTLE),
    .PASS_MIN (PASS_MIN),
    .TIMEOUT  (TIMEOUT),
    .PULSE    (PULSE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .passcount    (passcount),
    .failcount    (failcount),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .good_map     (good_map),
    .best         (best),
    .win_len      (win_len),
    .phase        (phase)
  );

  typedef struct {
    string       tag;
    logic [15:0] gm;
    logic [3:0]  best;
    logic [4:0]  wl;
    logic        fail;
    int          pulses;
    logic [3:0]  phase;
    int          busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Tester and PLL model controls, written only by the stimulus block.
  logic [15:0] good_mask = '0;
  logic [15:0] bad_mask  = '0;
  logic        tick_mode = 1'b0;
  logic [31:0] p_init    = '0;

  // Model state, written only by the model process.
  int          cyc         = 0;
  logic [3:0]  pll_phase   = '0;
  logic        step_prev   = 1'b0;
  int          pulses      = 0;
  int          busy_cycles = 0;

  // Behavioural tester + PLL: good phases advance passcount every busy
  // cycle, bad phases bump failcount every third cycle, tick mode bumps
  // failcount every tenth cycle, anything else leaves the counters frozen.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (reset) begin
      passcount   = p_init;
      failcount   = '0;
      pll_phase   = '0;
      step_prev   = 1'b0;
      pulses      = 0;
      busy_cycles = 0;
    end else begin
      if (phasestep && !step_prev) begin
        pll_phase = pll_phase + 4'd1;
        pulses++;
      end
      step_prev = phasestep;
      if (busy) busy_cycles++;
      if (tick_mode) begin
        if (cyc % 10 == 0) failcount = failcount + 32'd1;
      end else if (busy && good_mask[pll_phase]) begin
        passcount = passcount + 32'd1;
      end else if (busy && bad_mask[pll_phase] && (cyc % 3 == 0)) begin
        failcount = failcount + 32'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One full calibration: reset, push the expectation, start, wait for done,
  // pop and compare. busy_exp < 0 skips the busy-duration comparison.
  task automatic run_case(input string tag, input logic [15:0] gmask,
                          input logic [15:0] bmask, input logic tick,
                          input logic [31:0] pinit, input logic [15:0] e_gm,
                          input logic [3:0] e_best, input logic [4:0] e_wl,
                          input logic e_fail, input int busy_exp, input bit poke);
    exp_t e;
    int   n;
    good_mask = gmask;
    bad_mask  = bmask;
    tick_mode = tick;
    p_init    = pinit;
    apply_reset();

    e.tag         = tag;
    e.gm          = e_gm;
    e.best        = e_best;
    e.wl          = e_wl;
    e.fail        = e_fail;
    e.pulses      = STEPS + int'(e_best);
    e.phase       = e_best;
    e.busy_cycles = busy_exp;
    exp_q.push_back(e);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);

    if (poke) begin
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_poke"}, 32'(busy), 32'd1);
    end

    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end

    e = exp_q.pop_front();
    check({e.tag, "_done"},     32'(done),     32'd1);
    check({e.tag, "_busy_low"}, 32'(busy),     32'd0);
    check({e.tag, "_good_map"}, 32'(good_map), 32'(e.gm));
    check({e.tag, "_best"},     32'(best),     32'(e.best));
    check({e.tag, "_win_len"},  32'(win_len),  32'(e.wl));
    check({e.tag, "_fail"},     32'(fail),     32'(e.fail));
    check({e.tag, "_pulses"},   32'(pulses),   32'(e.pulses));
    check({e.tag, "_phase"},    32'(phase),    32'(e.phase));
    if (e.busy_cycles >= 0) begin
      check({e.tag, "_busy_cycles"}, 32'(busy_cycles), 32'(e.busy_cycles));
    end
  endtask

  initial begin
    int n;

    // Reset state: everything low and idle.
    apply_reset();
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_done",         32'(done),         32'd0);
    check("rst_fail",         32'(fail),         32'd0);
    check("rst_good_map",     32'(good_map),     32'd0);
    check("rst_best",         32'(best),         32'd0);
    check("rst_win_len",      32'(win_len),      32'd0);
    check("rst_phase",        32'(phase),        32'd0);
    check("rst_phasestep",    32'(phasestep),    32'd0);
    check("rst_phasedir",     32'(phasedir),     32'd0);
    check("rst_phaseloadreg", 32'(phaseloadreg), 32'd0);

    // Good window 3..9: centre 3 + 7/2 = 6.
    run_case("win3_9", 16'h03F8, 16'hFC07, 1'b0, 32'd0,
             16'h03F8, 4'd6, 5'd7, 1'b0, -1, 1'b0);

    // Window wrapping through 0: start 14, length 4, centre 16 mod 16 = 0.
    run_case("wrap_win", 16'hC003, 16'h3FFC, 1'b0, 32'd0,
             16'hC003, 4'd0, 5'd4, 1'b0, -1, 1'b0);

    // failcount moving every 10 cycles: every step bad.
    run_case("all_bad", 16'h0000, 16'h0000, 1'b1, 32'd0,
             16'h0000, 4'd0, 5'd0, 1'b1, -1, 1'b0);

    // Frozen tester: each step burns the whole timeout.
    // busy = STEPS*(SETTLE+1+TIMEOUT+2*PULSE) + 2*STEPS = 16*77 + 32.
    run_case("stalled", 16'h0000, 16'h0000, 1'b0, 32'd0,
             16'h0000, 4'd0, 5'd0, 1'b1, 1264, 1'b0);

    // passcount crosses 2^32 around step 0's snapshot; all steps good.
    run_case("pass_wrap", 16'hFFFF, 16'h0000, 1'b0, 32'hFFFF_FFF6,
             16'hFFFF, 4'd0, 5'd16, 1'b0, -1, 1'b0);

    // Two length-3 windows at 2 and 10: lower start wins, centre 3.
    // A start pulse mid-sweep must be ignored.
    run_case("tie_poke", 16'h1C1C, 16'hE3E3, 1'b0, 32'd0,
             16'h1C1C, 4'd3, 5'd3, 1'b0, -1, 1'b1);

    // Reset in the middle of step 2's measurement (steps 0,1 good,
    // step 2 stalled).
    good_mask = 16'h0003;
    bad_mask  = 16'h0000;
    tick_mode = 1'b0;
    p_init    = 32'd0;
    apply_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (pulses < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_step2", 32'(pulses), 32'd2);
    repeat (20) @(negedge clk);
    check("mid_pre_good_map", 32'(good_map), 32'h0003);
    check("mid_pre_phase",    32'(phase),    32'd2);
    check("mid_pre_busy",     32'(busy),     32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_done",      32'(done),      32'd0);
    check("mid_rst_phasestep", 32'(phasestep), 32'd0);
    check("mid_rst_good_map",  32'(good_map),  32'd0);
    check("mid_rst_phase",     32'(phase),     32'd0);
    check("mid_rst_best",      32'(best),      32'd0);
    check("mid_rst_win_len",   32'(win_len),   32'd0);
    check("mid_rst_fail",      32'(fail),      32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global bound in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
